// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board defaults, cell indexing,
// game condition codes and the mine placer state encoding.
package minesweeper_pkg;

    localparam int          ROWS_DEF      = 8;
    localparam int          COLS_DEF      = 8;
    localparam int          NUM_MINES_DEF = 10;
    localparam logic [15:0] SEED_DEF      = 16'hACE1;

    // Game condition reported by the top-level game FSM.
    typedef enum logic [1:0] {
        COND_PLAY = 2'd0,
        COND_WIN  = 2'd1,
        COND_LOSE = 2'd2
    } cond_t;

    // Mine placer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_DRAW  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } placer_state_t;

    // Flat bitmap index of cell (r,c) on a board that is 'cols' wide.
    function automatic logic [8:0] cell_idx(input logic [3:0] r,
                                            input logic [3:0] c,
                                            input int         cols);
        return 9'(int'(r) * cols + int'(c));
    endfunction

endpackage

// File: rtl/mine_placer_if.sv
// Handshake between the game FSM (master) and the mine placer (slave).
interface mine_placer_if
    import minesweeper_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) ();

    logic                   mine_start;
    logic [3:0]             safe_row;
    logic [3:0]             safe_col;
    logic                   mine_done;
    logic                   busy;
    logic [ROWS*COLS-1:0]   mine_map;
    logic [7:0]             mine_count;

    modport master (
        output mine_start, safe_row, safe_col,
        input  mine_done, busy, mine_map, mine_count
    );

    modport slave (
        input  mine_start, safe_row, safe_col,
        output mine_done, busy, mine_map, mine_count
    );

endinterface

// File: rtl/mine_placer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

    // Shift every cycle; reset reloads the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= seed;
        else      r_q <= {r_q[14:0], w_fb};
    end

    assign q = r_q;

endmodule

// File: rtl/mine_placer.sv
// Mine placer: on request clears the mine bitmap and drops NUM_MINES
// mines on pseudo-random cells outside the 3x3 zone around the
// player's first click, then holds done until the request drops.
module mine_placer
    import minesweeper_pkg::*;
#(
    parameter int          ROWS      = ROWS_DEF,
    parameter int          COLS      = COLS_DEF,
    parameter int          NUM_MINES = NUM_MINES_DEF,
    parameter logic [15:0] SEED      = SEED_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mine_placer_if.slave  bus
);

    localparam int          MAP_W    = ROWS * COLS;
    // An all-zero seed would lock the LFSR.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    generate
        if (ROWS < 4 || ROWS > 16 || COLS < 4 || COLS > 16) begin : g_bad_dims
            $error("mine_placer: ROWS and COLS must be within 4..16");
        end
        if (NUM_MINES < 1 || NUM_MINES > MAP_W - 9) begin : g_bad_mines
            $error("mine_placer: NUM_MINES must be within 1..ROWS*COLS-9");
        end
    endgenerate

    placer_state_t       r_state;
    logic [MAP_W-1:0]    r_map;
    logic [7:0]          r_count;
    logic [3:0]          r_safe_row;
    logic [3:0]          r_safe_col;
    logic [3:0]          r_cand_row;
    logic [3:0]          r_cand_col;
    logic                r_done;
    logic                r_busy;

    logic [15:0]         w_lfsr;
    logic [8:0]          w_idx;
    logic [MAP_W-1:0]    w_bit;
    logic signed [4:0]   w_dr;
    logic signed [4:0]   w_dc;
    logic                w_off_board;
    logic                w_occupied;
    logic                w_in_zone;
    logic                w_reject;
    logic [7:0]          w_new_count;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED_EFF),
        .q    (w_lfsr)
    );

    // Candidate evaluation. A candidate off the board may alias a real
    // cell in w_idx, but it is rejected by w_off_board regardless.
    assign w_idx       = cell_idx(r_cand_row, r_cand_col, COLS);
    assign w_bit       = MAP_W'(1) << w_idx;
    assign w_off_board = ({1'b0, r_cand_row} >= 5'(ROWS)) ||
                         ({1'b0, r_cand_col} >= 5'(COLS));
    assign w_occupied  = |(r_map & w_bit);
    // Signed differences so safe cells on an edge or corner clip naturally.
    assign w_dr        = $signed({1'b0, r_cand_row}) - $signed({1'b0, r_safe_row});
    assign w_dc        = $signed({1'b0, r_cand_col}) - $signed({1'b0, r_safe_col});
    assign w_in_zone   = (w_dr >= -5'sd1) && (w_dr <= 5'sd1) &&
                         (w_dc >= -5'sd1) && (w_dc <= 5'sd1);
    assign w_reject    = w_off_board || w_occupied || w_in_zone;
    assign w_new_count = r_count + 8'd1;

    // Placement FSM with registered done/busy; a dropped request aborts
    // from any working state without committing the pending candidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_map      <= '0;
            r_count    <= '0;
            r_safe_row <= '0;
            r_safe_col <= '0;
            r_cand_row <= '0;
            r_cand_col <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mine_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!bus.mine_start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_map      <= '0;
                        r_count    <= '0;
                        r_safe_row <= bus.safe_row;
                        r_safe_col <= bus.safe_col;
                        r_state    <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (!bus.mine_start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cand_row <= w_lfsr[3:0];
                        r_cand_col <= w_lfsr[7:4];
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!bus.mine_start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_reject) begin
                        r_state <= ST_DRAW;
                    end else begin
                        r_map   <= r_map | w_bit;
                        r_count <= w_new_count;
                        if (w_new_count == 8'(NUM_MINES)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAW;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.mine_start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mine_done  = r_done;
    assign bus.busy       = r_busy;
    assign bus.mine_map   = r_map;
    assign bus.mine_count = r_count;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: directed game sequences with random start
// delays, compared against a game-level placement model.
module tb_mine_placer;
    import minesweeper_pkg::*;

    localparam int          ROWS = 8;
    localparam int          COLS = 8;
    localparam int          NM   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    mine_placer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    mine_placer #(.ROWS(ROWS), .COLS(COLS), .NUM_MINES(NM), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Entropy value currently presented by the generator.
    logic [15:0] q_now;
    always @(posedge clk or negedge rst) begin
        if (!rst) q_now <= SEED;
        else      q_now <= step(q_now);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Attempt k draws the entropy value seen just before edge E0+2+2k.
    function automatic void predict(input logic [15:0] q0, input int sr, input int sc,
                                    input int max_att, output logic [63:0] map,
                                    output int cnt, output int att);
        logic [15:0] q;
        int r, c;
        map = '0; cnt = 0; att = 0;
        q = step(step(q0));
        while (cnt < NM && att < max_att) begin
            r = int'(q[3:0]);
            c = int'(q[7:4]);
            att++;
            if (r < ROWS && c < COLS) begin
                if (!map[r*COLS+c] &&
                    !((r - sr) <= 1 && (sr - r) <= 1 && (c - sc) <= 1 && (sc - c) <= 1)) begin
                    map[r*COLS+c] = 1'b1;
                    cnt++;
                end
            end
            q = step(step(q));
        end
    endfunction

    function automatic logic [63:0] zone(input int sr, input int sc);
        logic [63:0] z = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((r - sr) <= 1 && (sr - r) <= 1 && (c - sc) <= 1 && (sc - c) <= 1)
                    z[r*COLS+c] = 1'b1;
        return z;
    endfunction

    // One full game from IDLE: start, wait for done, check, hold, release.
    task automatic run_game(input int sr, input int sc, input int hold);
        logic [63:0] emap;
        int ecnt, eatt, lat, lim;
        bus.safe_row = 4'(sr);
        bus.safe_col = 4'(sc);
        predict(q_now, sr, sc, 100000, emap, ecnt, eatt);
        bus.mine_start = 1'b1;
        lim = 2 + 2 * eatt + 8;
        lat = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_clear", 64'(bus.busy), 64'd1);
            if (i == 2) begin
                chk("clear_count", 64'(bus.mine_count), 64'd0);
                chk("clear_map", bus.mine_map, 64'd0);
            end
            if (bus.mine_done) begin
                lat = i;
                break;
            end
        end
        chk("done_latency", 64'(lat), 64'(2 + 2 * eatt));
        chk("final_map", bus.mine_map, emap);
        chk("final_count", 64'(bus.mine_count), 64'(NM));
        chk("popcount", 64'($countones(bus.mine_map)), 64'(NM));
        chk("safe_zone", bus.mine_map & zone(sr, sc), 64'd0);
        chk("busy_done", 64'(bus.busy), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_done", 64'(bus.mine_done), 64'd1);
            chk("hold_map", bus.mine_map, emap);
        end
        bus.mine_start = 1'b0;
        @(negedge clk);
        chk("release_done", 64'(bus.mine_done), 64'd0);
        chk("release_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pmap;
        int pcnt, patt;

        bus.mine_start = 1'b0;
        bus.safe_row   = 4'd0;
        bus.safe_col   = 4'd0;
        #1;
        chk("rst_done", 64'(bus.mine_done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_map", bus.mine_map, 64'd0);
        chk("rst_count", 64'(bus.mine_count), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Safe corner, held five cycles past done.
        run_game(0, 0, 5);

        // Fresh game in the opposite corner.
        repeat (3) @(negedge clk);
        run_game(7, 7, 0);

        // Abort mid-placement: two attempts commit, then the request drops.
        repeat (2) @(negedge clk);
        bus.safe_row = 4'd2;
        bus.safe_col = 4'd5;
        predict(q_now, 2, 5, 2, pmap, pcnt, patt);
        bus.mine_start = 1'b1;
        repeat (6) @(negedge clk);
        bus.mine_start = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.mine_done), 64'd0);
        chk("abort_count", 64'(bus.mine_count), 64'(pcnt));
        chk("abort_map", bus.mine_map, pmap);
        @(negedge clk);
        chk("abort_done2", 64'(bus.mine_done), 64'd0);

        // Restart after the abort must re-clear the partial map.
        run_game(7, 7, 0);

        // Random start delays around a centre safe cell.
        for (int g = 0; g < 200; g++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run_game(4, 4, 0);
        end

        // Off-board safe cell.
        run_game(12, 3, 1);

        // Reset asserted mid-DRAW.
        bus.safe_row = 4'd3;
        bus.safe_col = 4'd3;
        bus.mine_start = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.mine_done), 64'd0);
        chk("midrst_map", bus.mine_map, 64'd0);
        chk("midrst_count", 64'(bus.mine_count), 64'd0);
        bus.mine_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_busy", 64'(bus.busy), 64'd0);
        run_game(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mine_placer.md
# mine_placer

Responder side of the mine-placement handshake driven by the top-level game FSM. When `mine_start` rises, the block clears the board's mine bitmap and places exactly `NUM_MINES` mines at pseudo-random cells. It never places a mine in the 3×3 safe zone around the player's first-selected cell. It then holds `mine_done` until the game FSM releases `mine_start`. The resulting `mine_map` feeds the adjacency counter and reveal logic.

## Interface
Parameters:
- `ROWS`, default 8: board rows, 4..16.
- `COLS`, default 8: board columns, 4..16.
- `NUM_MINES`, default 10: mines per game, 1..ROWS*COLS-9. Elaboration fails outside this range.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports (reset is `rst`, asynchronous, active-low; clock is `clk`):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-low reset.
- `mine_start`, in, 1: level request from the game FSM, held high for the whole placement.
- `safe_row`, in, 4: row of the first-selected cell, sampled in CLEAR.
- `safe_col`, in, 4: column of the first-selected cell, sampled in CLEAR.
- `mine_done`, out, 1: high in DONE state only.
- `busy`, out, 1: high in CLEAR, DRAW or CHECK.
- `mine_map`, out, ROWS*COLS: bit r*COLS+c is 1 when cell (r,c) holds a mine.
- `mine_count`, out, 8: mines placed so far.

## Operation
- Entropy source is a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every cycle in every state, so the mine layout depends on when the player clicks.
- Each candidate uses `cand_row` = lfsr[3:0] and `cand_col` = lfsr[7:4].

State machine:
- IDLE: if `mine_start`=1, go to CLEAR.
- CLEAR: zero `mine_map` and `mine_count`, latch `safe_row`/`safe_col`, go to DRAW.
- DRAW: register `cand_row`/`cand_col`, go to CHECK.
- CHECK: reject the candidate if any of these hold:
  - `cand_row` ≥ ROWS or `cand_col` ≥ COLS;
  - the cell is already set;
  - |cand_row−safe_row| ≤ 1 and |cand_col−safe_col| ≤ 1. Use signed 5-bit differences, so edge and corner safe cells clip naturally.
- CHECK on accept: set the bit and increment `mine_count`. If the new count equals NUM_MINES, go to DONE, otherwise go to DRAW.
- CHECK on reject: go to DRAW with the map unchanged.
- DONE: `mine_done`=1. Go to IDLE when `mine_start`=0.

Abort and edge cases:
- `mine_start`=0 in CLEAR, DRAW or CHECK aborts to IDLE on the next edge. The partial map is kept, `mine_done` never asserts, and CHECK commits nothing in that cycle.
- An unused state encoding goes to IDLE.
- A new `mine_start` after DONE→IDLE (board reset) always re-clears the map. No stale mines survive into a new game.
- `safe_row`/`safe_col` outside the board are legal. The safe zone then excludes fewer or no cells.

## Timing
- Reset values: state IDLE, `mine_map`=0, `mine_count`=0, `mine_done`=0, `busy`=0, LFSR=SEED.
- All outputs are registered or Moore decodes of state; there are no combinational paths from inputs.
- Let E0 be the edge that samples `mine_start`=1 in IDLE:
  - CLEAR is active after E0.
  - The first DRAW is active after E0+1.
  - Each attempt takes 2 cycles.
- Minimum latency with zero rejects: `mine_done` is high after edge E0+1+2·NUM_MINES (21 cycles for the defaults).
- Worst case is bounded by the LFSR period: every (row,col) pair recurs within 65535 cycles, so termination is guaranteed.
- `mine_done` falls on the first edge after `mine_start` is sampled low.
- `mine_map` is stable whenever `mine_done`=1.

## Structure
- Shared package `minesweeper_pkg` holds:
  - ROWS, COLS and NUM_MINES defaults;
  - the `cell_idx(r,c)` function;
  - the `cond` encoding (0 play, 1 win, 2 lose);
  - the placer state encoding IDLE=0, CLEAR=1, DRAW=2, CHECK=3, DONE=4.
- One sub-module, `lfsr16`, with ports clk, rst, seed and q[15:0]. It always runs and loads `seed` on reset.
- Expected size is about 150 lines of RTL.

## Test plan
- Defaults, SEED=16'hACE1, safe (0,0), `mine_start` held → `mine_done` rises; popcount(`mine_map`)=10; bits for (0,0),(0,1),(1,0),(1,1) all 0; `mine_count`=10.
- Safe (4,4), 200 games with random start delays → every game ends with 10 mines and no mine in rows 3–5 × cols 3–5.
- Drop `mine_start` 6 cycles after E0 → `busy` falls next edge, `mine_done` stays 0, `mine_count` ≤ 2.
- Full game, drop `mine_start`, restart with safe (7,7) → map cleared in CLEAR (`mine_count`=0), final map has 10 fresh mines and none in rows 6–7 × cols 6–7.
- Hold `mine_start` 5 cycles past DONE → `mine_done` stays high, `mine_map` is unchanged, and `mine_done` falls one edge after the release.
- Assert `rst`=0 mid-DRAW → all outputs zero immediately; after release, the LFSR restarts at SEED and IDLE is re-entered.
